// File: rtl/seg_display.sv
// -----------------------------------------------------------------------------
// seg_display
//   Four-digit multiplexed seven-segment display driver, programmed by a
//   sequencer through a 12-bit instruction word (opcode + 8-bit immediate).
//   Digits are scanned one at a time, each lit for ScanDiv clock cycles.
//
// Parameters
//   ScanDiv   : clock cycles each digit is lit per scan step
//   ScanSize  : width of the scan counter (ScanDiv-1 must fit)
//
// Ports
//   clock     : single clock, rising edge
//   reset     : synchronous reset, active-low
//   inst      : instruction word; inst[11:8] opcode, inst[7:0] immediate
//   inst_en   : inst is addressed to this block in this cycle
//   seg       : segments a..g on seg[0]..seg[6], active-low
//   dp        : decimal point, active-low
//   an        : digit anodes, active-low, an[i] selects digit i
// -----------------------------------------------------------------------------
module seg_display #(
    parameter int ScanDiv  = 50000,
    parameter int ScanSize = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDL = 4'd1;
    localparam logic [3:0] OP_LDH = 4'd2;
    localparam logic [3:0] OP_LDD = 4'd3;
    localparam logic [3:0] OP_BLK = 4'd4;
    localparam logic [3:0] OP_ON  = 4'd5;
    localparam logic [3:0] OP_OFF = 4'd6;
    localparam logic [3:0] OP_CLR = 4'd7;

    localparam logic [ScanSize-1:0] SCAN_LAST = ScanSize'(ScanDiv - 1);

    state_t                state;
    state_t                state_nxt;
    logic [3:0][3:0]       digits;
    logic [3:0]            dp_mask;
    logic [3:0]            blank_mask;
    logic                  enable;
    logic [ScanSize-1:0]   scan_cnt;
    logic [1:0]            digit_idx;

    logic [3:0]            opcode;
    logic [7:0]            imm;
    logic                  accept;
    logic                  lit;

    assign opcode = inst[11:8];
    assign imm    = inst[7:0];
    // Instructions are only honoured in Ready; Reset and Error drop them.
    assign accept = (state == ST_READY) && inst_en;

    // Active-low hex glyph, bit order g f e d c b a.
    function automatic logic [6:0] hex_glyph(input logic [3:0] val);
        case (val)
            4'h0:    hex_glyph = 7'b1000000;
            4'h1:    hex_glyph = 7'b1111001;
            4'h2:    hex_glyph = 7'b0100100;
            4'h3:    hex_glyph = 7'b0110000;
            4'h4:    hex_glyph = 7'b0011001;
            4'h5:    hex_glyph = 7'b0010010;
            4'h6:    hex_glyph = 7'b0000010;
            4'h7:    hex_glyph = 7'b1111000;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0010000;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b0000011;
            4'hC:    hex_glyph = 7'b1000110;
            4'hD:    hex_glyph = 7'b0100001;
            4'hE:    hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset always steps to Ready; any opcode with bit 3 set traps in Error.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET: state_nxt = ST_READY;
            ST_READY: begin
                if (inst_en && opcode[3]) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            digits     <= '0;
            dp_mask    <= '0;
            blank_mask <= '0;
            enable     <= 1'b0;
            scan_cnt   <= '0;
            digit_idx  <= '0;
        end else begin
            // Scanning runs in Ready and Error, independent of enable.
            if (state != ST_RESET) begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt  <= '0;
                    digit_idx <= digit_idx + 2'd1;
                end else begin
                    scan_cnt  <= scan_cnt + ScanSize'(1);
                end
            end
            if (accept) begin
                case (opcode)
                    OP_NOP: ;
                    OP_LDL: begin
                        digits[0] <= imm[3:0];
                        digits[1] <= imm[7:4];
                    end
                    OP_LDH: begin
                        digits[2] <= imm[3:0];
                        digits[3] <= imm[7:4];
                    end
                    OP_LDD: dp_mask    <= imm[3:0];
                    OP_BLK: blank_mask <= imm[3:0];
                    OP_ON:  enable     <= 1'b1;
                    OP_OFF: enable     <= 1'b0;
                    OP_CLR: begin
                        digits     <= '0;
                        dp_mask    <= '0;
                        blank_mask <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs decode straight from registered state so a load is visible on
    // the cycle after it is accepted. A dark digit forces seg and dp high too.
    always_comb begin
        lit = (state == ST_READY) && enable && !blank_mask[digit_idx];
        an  = 4'b1111;
        seg = 7'b1111111;
        dp  = 1'b1;
        if (lit) begin
            an  = ~(4'b0001 << digit_idx);
            seg = hex_glyph(digits[digit_idx]);
            dp  = ~dp_mask[digit_idx];
        end
    end

endmodule

// File: tb/tb_seg_display.sv
module tb_seg_display;

    localparam int SCAN_DIV = 4;

    localparam logic [6:0] G0  = 7'b1000000;
    localparam logic [6:0] G1  = 7'b1111001;
    localparam logic [6:0] G2  = 7'b0100100;
    localparam logic [6:0] G3  = 7'b0110000;
    localparam logic [6:0] G4  = 7'b0011001;
    localparam logic [6:0] G8  = 7'b0000000;
    localparam logic [6:0] GC  = 7'b1000110;
    localparam logic [6:0] GD  = 7'b0100001;
    localparam logic [6:0] GE  = 7'b0000110;
    localparam logic [6:0] GF  = 7'b0001110;
    localparam logic [6:0] OFF = 7'b1111111;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] inst = '0;
    logic        inst_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    always #5 clock = ~clock;

    seg_display #(.ScanDiv(SCAN_DIV), .ScanSize(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .inst    (inst),
        .inst_en (inst_en),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    // Expected scan position, advanced once per clock by the stimulus.
    int    cnt = 0;
    int    idx = 0;
    bit    run = 1'b0;

    // Hand-set expected outputs for each digit slot.
    logic [3:0] t_an  [4];
    logic [6:0] t_seg [4];
    logic       t_dp  [4];

    task automatic tick();
        @(posedge clock);
        if (!reset) begin
            cnt = 0;
            idx = 0;
            run = 1'b0;
        end else if (run) begin
            if (cnt == SCAN_DIV - 1) begin
                cnt = 0;
                idx = (idx + 1) % 4;
            end else begin
                cnt++;
            end
        end else begin
            run = 1'b1;
        end
        #1;
    endtask

    task automatic expect_now(input string nm);
        exp_t e;
        e.an  = t_an[idx];
        e.seg = t_seg[idx];
        e.dp  = t_dp[idx];
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_off(input string nm);
        checks++;
        if (an !== 4'hF || seg !== OFF || dp !== 1'b1) begin
            failures++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want display off",
                     nm, an, seg, dp);
        end
    endtask

    task automatic set_all_off();
        for (int i = 0; i < 4; i++) begin
            t_an[i]  = 4'hF;
            t_seg[i] = OFF;
            t_dp[i]  = 1'b1;
        end
    endtask

    task automatic set_digit(input int i, input logic [6:0] g, input logic d, input bit on);
        t_an[i]  = on ? ~(4'b0001 << i) : 4'hF;
        t_seg[i] = on ? g : OFF;
        t_dp[i]  = on ? d : 1'b1;
    endtask

    task automatic cycles(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            tick();
            expect_now(nm);
        end
    endtask

    task automatic op(input logic [3:0] o, input logic [7:0] imm, input string nm);
        inst    = {o, imm};
        inst_en = 1'b1;
        tick();
        inst_en = 1'b0;
        inst    = '0;
        expect_now(nm);
    endtask

    task automatic do_reset(input string nm);
        set_all_off();
        reset = 1'b0;
        tick();
        expect_now({nm, "_hold"});
        check_off({nm, "_hold_state"});
        tick();
        expect_now({nm, "_hold"});
        reset = 1'b1;
        tick();
        expect_now({nm, "_release"});
    endtask

    // Monitor: outputs are sampled on the falling edge, away from updates.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                failures++;
                $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                         n, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    initial begin
        // Basic load and scan order.
        do_reset("t1_rst");
        op(4'h1, 8'h21, "t1_ldl");
        op(4'h2, 8'h43, "t1_ldh");
        set_digit(0, G1, 1'b1, 1'b1);
        set_digit(1, G2, 1'b1, 1'b1);
        set_digit(2, G3, 1'b1, 1'b1);
        set_digit(3, G4, 1'b1, 1'b1);
        op(4'h5, 8'h00, "t1_on");
        op(4'h0, 8'hFF, "t1_nop");
        cycles(16, "t1_scan");

        // Decimal points and blanking on a freshly reset block.
        do_reset("t2_rst");
        for (int i = 0; i < 4; i++) set_digit(i, G0, 1'b1, 1'b1);
        op(4'h5, 8'h00, "t2_on");
        set_digit(0, G8, 1'b1, 1'b1);
        set_digit(1, G8, 1'b1, 1'b1);
        op(4'h1, 8'h88, "t2_ldl");
        set_digit(0, G8, 1'b0, 1'b1);
        set_digit(2, G0, 1'b0, 1'b1);
        op(4'h3, 8'h05, "t2_ldd");
        set_digit(1, G8, 1'b1, 1'b0);
        op(4'h4, 8'h02, "t2_blk");
        cycles(16, "t2_scan");

        // Instruction in the first cycle after release must be ignored.
        set_all_off();
        reset = 1'b0;
        tick();
        expect_now("t3_rst_hold");
        reset   = 1'b1;
        inst    = {4'h5, 8'h00};
        inst_en = 1'b1;
        tick();
        inst_en = 1'b0;
        inst    = '0;
        expect_now("t3_early_on");
        cycles(8, "t3_still_off");
        for (int i = 0; i < 4; i++) set_digit(i, G0, 1'b1, 1'b1);
        op(4'h5, 8'h00, "t3_on");
        cycles(4, "t3_scan");

        // Illegal opcode traps in Error until reset.
        set_all_off();
        op(4'h9, 8'h00, "t4_err");
        op(4'h5, 8'h00, "t4_on_ignored");
        op(4'h1, 8'h21, "t4_ldl_ignored");
        cycles(8, "t4_err_hold");
        check_off("t4_err_state");
        do_reset("t4_rst");
        cycles(2, "t4_after_rst");

        // Hex glyphs, CLR keeps enable, OFF/CLR/ON, reset mid digit-2 step.
        op(4'h1, 8'hDC, "t5_ldl");
        op(4'h2, 8'hFE, "t5_ldh");
        op(4'h3, 8'h0F, "t5_ldd");
        set_digit(0, GC, 1'b0, 1'b1);
        set_digit(1, GD, 1'b0, 1'b1);
        set_digit(2, GE, 1'b0, 1'b1);
        set_digit(3, GF, 1'b0, 1'b1);
        op(4'h5, 8'h00, "t5_on");
        cycles(16, "t5_hex");
        for (int i = 0; i < 4; i++) set_digit(i, G0, 1'b1, 1'b1);
        op(4'h7, 8'h00, "t5_clr_while_on");
        cycles(4, "t5_clr_scan");
        set_digit(0, G1, 1'b1, 1'b1);
        set_digit(1, G2, 1'b1, 1'b1);
        op(4'h1, 8'h21, "t5_reload");
        cycles(8, "t5_reload_scan");
        set_all_off();
        op(4'h6, 8'h00, "t5_off");
        cycles(4, "t5_off_scan");
        op(4'h7, 8'h00, "t5_clr");
        for (int i = 0; i < 4; i++) set_digit(i, G0, 1'b1, 1'b1);
        op(4'h5, 8'h00, "t5_on2");
        cycles(16, "t5_zero_scan");
        for (int k = 0; k < 16 && idx != 2; k++) begin
            tick();
            expect_now("t5_seek_d2");
        end
        tick();
        expect_now("t5_in_d2");
        set_all_off();
        reset = 1'b0;
        tick();
        expect_now("t5_rst_mid_d2");
        check_off("t5_rst_mid_d2_state");
        reset = 1'b1;
        tick();
        expect_now("t5_rst_release");

        @(negedge clock);
        #1;
        while (exp_q.size() > 0) begin
            string n;
            void'(exp_q.pop_front());
            n = name_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: expectation expired without being checked", n);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
